// File: rtl/fe_8b10b_pkg.sv
// fe_8b10b_pkg: shared K-codes, legal-K list, disparity encoding and tx state type
package fe_8b10b_pkg;
  localparam logic RD_NEG = 1'b0;
  localparam logic [7:0] K28_0 = 8'h1C, K28_1 = 8'h3C, K28_2 = 8'h5C, K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C, K28_5 = 8'hBC, K28_6 = 8'hDC, K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7, K27_7 = 8'hFB, K29_7 = 8'hFD, K30_7 = 8'hFE;
  localparam logic [11:0][7:0] LEGAL_K = {K28_0, K28_1, K28_2, K28_3, K28_4, K28_5,
                                          K28_6, K28_7, K23_7, K27_7, K29_7, K30_7};
  typedef enum logic {OFF, RUN} tx_state_t;
  function automatic logic legal_k(input logic [7:0] d);
    legal_k = 1'b0;
    for (int i = 0; i < 12; i++) legal_k |= (d == LEGAL_K[i]);
  endfunction
endpackage

// File: rtl/fe_8b10b_tx_encode.sv
// encode_8b10b: combinational IEEE 8b10b encoder, CODE[9:0] = abcdeifghj
module encode_8b10b
  import fe_8b10b_pkg::*;
(
  input  logic [7:0] DATA,
  input  logic       K,
  input  logic       RD_IN,
  output logic [9:0] CODE,
  output logic       RD_OUT,
  output logic       K_ERR
);
  localparam logic [7:0][3:0] D4 = {4'b1110, 4'b0110, 4'b1010, 4'b1101,
                                    4'b1100, 4'b0101, 4'b1001, 4'b1011};
  localparam logic [7:0][3:0] K4 = {4'b0111, 4'b1001, 4'b0101, 4'b1101,
                                    4'b1100, 4'b1010, 4'b0110, 4'b1011};
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] d6, t6;
  logic [3:0] t4;
  logic unbal6, unbal4, rd6, alt7;
  assign x = DATA[4:0];
  assign y = DATA[7:5];
  assign K_ERR = K & !legal_k(DATA);
  // 6b codes stored in their RD- form; RD+ form is the complement when unbalanced (and for D.7)
  always_comb begin
    d6 = 6'b000000;
    case (x)
      5'd0:  d6 = 6'b100111;
      5'd1:  d6 = 6'b011101;
      5'd2:  d6 = 6'b101101;
      5'd3:  d6 = 6'b110001;
      5'd4:  d6 = 6'b110101;
      5'd5:  d6 = 6'b101001;
      5'd6:  d6 = 6'b011001;
      5'd7:  d6 = 6'b111000;
      5'd8:  d6 = 6'b111001;
      5'd9:  d6 = 6'b100101;
      5'd10: d6 = 6'b010101;
      5'd11: d6 = 6'b110100;
      5'd12: d6 = 6'b001101;
      5'd13: d6 = 6'b101100;
      5'd14: d6 = 6'b011100;
      5'd15: d6 = 6'b010111;
      5'd16: d6 = 6'b011011;
      5'd17: d6 = 6'b100011;
      5'd18: d6 = 6'b010011;
      5'd19: d6 = 6'b110010;
      5'd20: d6 = 6'b001011;
      5'd21: d6 = 6'b101010;
      5'd22: d6 = 6'b011010;
      5'd23: d6 = 6'b111010;
      5'd24: d6 = 6'b110011;
      5'd25: d6 = 6'b100110;
      5'd26: d6 = 6'b010110;
      5'd27: d6 = 6'b110110;
      5'd28: d6 = 6'b001110;
      5'd29: d6 = 6'b101110;
      5'd30: d6 = 6'b011110;
      5'd31: d6 = 6'b101011;
      default: d6 = 6'b000000;
    endcase
  end
  assign t6 = (K && x == 5'd28) ? 6'b001111 : d6;
  assign unbal6 = $countones(t6) != 3;
  assign rd6 = RD_IN ^ unbal6;
  assign alt7 = y == 3'd7 && (K || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                              (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
  assign t4 = alt7 ? 4'b0111 : K ? K4[y] : D4[y];
  assign unbal4 = $countones(t4) != 2;
  assign CODE = {(RD_IN && (unbal6 || x == 5'd7)) ? ~t6 : t6,
                 (rd6 && (K || unbal4 || y == 3'd3)) ? ~t4 : t4};
  assign RD_OUT = rd6 ^ unbal4;
endmodule

// File: rtl/fe_8b10b_tx.sv
// fe_8b10b_tx: valid/ready byte stream to serial 8b10b line with automatic comma idle
module fe_8b10b_tx
  import fe_8b10b_pkg::*;
#(
  parameter int          CLKDV     = 1,
  parameter logic [7:0]  IDLE_CHAR = K28_5
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        EN,
  input  logic [7:0]  DATA_IN,
  input  logic        DATA_K,
  input  logic        DATA_VALID,
  output logic        DATA_READY,
  output logic        TX_OUT,
  output logic        IDLE,
  output logic        CODE_ERR,
  output logic [15:0] SYM_CNT
);
  localparam int DW = CLKDV > 1 ? $clog2(CLKDV) : 1;
  tx_state_t state;
  logic [DW-1:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [9:0] sh, d_code, i_code, code;
  logic rd, d_rd, i_rd, d_kerr, idle_kerr_unused, bit_tick, load, use_idle;
  encode_8b10b u_dat (.DATA(DATA_IN), .K(DATA_K), .RD_IN(rd), .CODE(d_code), .RD_OUT(d_rd), .K_ERR(d_kerr));
  encode_8b10b u_idl (.DATA(IDLE_CHAR), .K(1'b1), .RD_IN(rd), .CODE(i_code), .RD_OUT(i_rd), .K_ERR(idle_kerr_unused));
  assign bit_tick = div_cnt == DW'(CLKDV - 1);
  assign load = EN & (state == OFF || (bit_tick && bit_cnt == 4'd9));
  assign use_idle = !DATA_VALID | d_kerr;
  assign code = use_idle ? i_code : d_code;
  // reset gating keeps the handshake quiet while RST_B is low even with EN high
  assign DATA_READY = load & RST_B;
  assign CODE_ERR = DATA_READY & DATA_VALID & d_kerr;
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state <= OFF;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      rd <= RD_NEG;
      TX_OUT <= 1'b0;
      IDLE <= 1'b0;
      SYM_CNT <= '0;
    end else if (!EN) begin
      state <= OFF;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      rd <= RD_NEG;
      TX_OUT <= 1'b0;
      IDLE <= 1'b0;
    end else if (load) begin
      state <= RUN;
      div_cnt <= '0;
      bit_cnt <= '0;
      TX_OUT <= code[9];
      sh <= {code[8:0], 1'b0};
      rd <= use_idle ? i_rd : d_rd;
      IDLE <= !DATA_VALID;
      SYM_CNT <= SYM_CNT + {15'd0, DATA_VALID};
    end else begin
      div_cnt <= bit_tick ? '0 : div_cnt + DW'(1);
      if (bit_tick) begin
        bit_cnt <= bit_cnt + 4'd1;
        TX_OUT <= sh[9];
        sh <= {sh[8:0], 1'b0};
      end
    end
  end
endmodule
